// File: rtl/tx_ctrl_pkg.sv
// Shared types and encodings for the tx_ctrl serial transmitter.
// The PARITY state exists only when TX_PARITY_EN is defined.
package tx_ctrl_pkg;

  localparam int TICKS_PER_BIT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_e;

  localparam logic [1:0] BPC_5 = 2'b00;
  localparam logic [1:0] BPC_6 = 2'b01;
  localparam logic [1:0] BPC_7 = 2'b10;
  localparam logic [1:0] BPC_8 = 2'b11;

  localparam logic [1:0] PAR_EVEN = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_NONE = 2'b10;

  function automatic logic [7:0] char_mask(input logic [1:0] bpc);
    case (bpc)
      BPC_5:   return 8'h1F;
      BPC_6:   return 8'h3F;
      BPC_7:   return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

  // Parity over the sent bits only; odd mode inverts the even result.
  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] bpc,
                                      input logic [1:0] mode);
    return (^(d & char_mask(bpc))) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/tx_baud_div.sv
// Bit-time counter: counts baud_tick pulses, strobes bit_done on the last tick of a bit.
module tx_baud_div #(
  parameter int TICKS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic baud_tick,
  output logic bit_done
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt_q;

  assign bit_done = baud_tick && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr)  cnt_q <= '0;
    else if (baud_tick) cnt_q <= bit_done ? '0 : cnt_q + CW'(1);
  end

endmodule

// File: rtl/tx_ctrl.sv
// Serial transmitter: THR + shifter with START/DATA/STOP framing.
// Define TX_PARITY_EN to add parity_mode and the PARITY state.
module tx_ctrl
  import tx_ctrl_pkg::*;
#(
  parameter int TICKS_PER_BIT = TICKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire  [7:0] data,
  input  logic       r_w,
  input  logic       thr_cs,
  input  logic       TxEN,
  input  logic       TxReset,
  input  logic       baud_tick,
  input  logic [1:0] bits_per_char,
`ifdef TX_PARITY_EN
  input  logic [1:0] parity_mode,
`endif
  output logic       TxD,
  output logic       TxRDY,
  output logic       TxEMT
);

  tx_state_e  state_q, state_d;
  logic [7:0] thr_q, thr_d;
  logic       thr_full_q, thr_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [2:0] last_q, last_d;
  logic       wr_prev_q;
  logic       tx_rdy_q, tx_emt_q;
  logic       wr_ok, load, bit_done;
`ifdef TX_PARITY_EN
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;
`endif

  // A write is the first cycle of a thr_cs/write assertion only.
  assign wr_ok = thr_cs && !r_w && !wr_prev_q && tx_rdy_q && TxEN;

  tx_baud_div #(.TICKS(TICKS_PER_BIT)) u_baud_div (
    .clk       (clk),
    .reset     (reset),
    .clr       ((state_q == IDLE) || !TxReset),
    .baud_tick (baud_tick),
    .bit_done  (bit_done)
  );

  always_comb begin
    state_d    = state_q;
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    last_d     = last_q;
    load       = 1'b0;
`ifdef TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif
    case (state_q)
      IDLE:  if (thr_full_q && TxEN) begin
               load    = 1'b1;
               state_d = START;
             end
      START: if (bit_done) state_d = DATA;
      DATA:  if (bit_done) begin
               if (bit_idx_q == last_q) begin
`ifdef TX_PARITY_EN
                 state_d = par_en_q ? PARITY : STOP;
`else
                 state_d = STOP;
`endif
               end else begin
                 shift_d   = shift_q >> 1;
                 bit_idx_d = bit_idx_q + 3'd1;
               end
             end
`ifdef TX_PARITY_EN
      PARITY: if (bit_done) state_d = STOP;
`endif
      // Reload after STOP ignores TxEN so a queued character still drains.
      STOP:  if (bit_done) begin
               if (thr_full_q) begin
                 load    = 1'b1;
                 state_d = START;
               end else begin
                 state_d = IDLE;
               end
             end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d    = thr_q;
      bit_idx_d  = 3'd0;
      last_d     = {1'b1, bits_per_char};
      thr_full_d = 1'b0;
`ifdef TX_PARITY_EN
      par_en_d   = !parity_mode[1];
      par_bit_d  = parity_bit(thr_q, bits_per_char, parity_mode);
`endif
    end
    // Write lands after the transfer so both can share a cycle.
    if (wr_ok) begin
      thr_d      = data;
      thr_full_d = 1'b1;
    end
    if (!TxReset) begin
      state_d    = IDLE;
      thr_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      thr_q      <= '0;
      thr_full_q <= 1'b0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      last_q     <= '0;
      wr_prev_q  <= 1'b0;
      tx_rdy_q   <= 1'b0;
      tx_emt_q   <= 1'b1;
`ifdef TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      thr_full_q <= thr_full_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      last_q     <= last_d;
      wr_prev_q  <= thr_cs && !r_w;
      tx_rdy_q   <= !thr_full_d && TxEN;
      tx_emt_q   <= !thr_full_d && (state_d == IDLE);
`ifdef TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

  always_comb begin
    TxD = 1'b1;
    case (state_q)
      START:  TxD = 1'b0;
      DATA:   TxD = shift_q[0];
`ifdef TX_PARITY_EN
      PARITY: TxD = par_bit_q;
`endif
      default: TxD = 1'b1;
    endcase
  end

  assign TxRDY = tx_rdy_q;
  assign TxEMT = tx_emt_q;

endmodule

// File: doc/tx_ctrl.md
TX_CTRL -- requirements
Module: tx_ctrl

Interface
REQ-001 SHALL have parameter TICKS_PER_BIT, default 16, meaning baud_tick pulses per serial bit.
REQ-002 SHALL have one clock and a synchronous, active-high reset, with ports named and ordered as follows:
  clk  input  1  system clock, all logic on posedge.
  reset  input  1  synchronous, active-high.
  data  inout  8  CPU bus, sampled only; never driven, always 'z'.
  r_w  input  1  1 = read, 0 = write.
  thr_cs  input  1  select for the transmit holding register (THR).
  TxEN  input  1  transmitter enable.
  TxReset  input  1  active-low transmitter reset command.
  baud_tick  input  1  one-cycle pulse at TICKS_PER_BIT times the bit rate.
  bits_per_char  input  2  character length: 00 = 5, 01 = 6, 10 = 7, 11 = 8 bits.
  TxD  output  1  serial line, idle high.
  TxRDY  output  1  THR can accept a character.
  TxEMT  output  1  THR empty and shifter idle.

Function
REQ-003 SHALL accept a THR write only in the first cycle of a thr_cs=1, r_w=0 assertion; a write needs a deassertion before it repeats.
REQ-004 SHALL ignore a write when TxRDY=0 or TxEN=0; THR contents SHALL be unchanged.
REQ-005 SHALL drive TxRDY = THR empty AND TxEN, registered, valid the cycle after any change.
REQ-006 SHALL drive TxEMT = THR empty AND state==IDLE, registered.
REQ-007 SHALL use the states IDLE, START, DATA, PARITY (only with TX_PARITY_EN) and STOP.
REQ-008 IDLE: while THR is full and TxEN=1, SHALL move THR to the shifter, mark THR empty, and go to START in the same cycle.
REQ-009 SHALL count bit time in baud_tick pulses only; each state SHALL last exactly TICKS_PER_BIT ticks.
REQ-010 TxD SHALL be 0 in START, the shifter bit (LSB first) in DATA, the parity bit in PARITY, and 1 in STOP and IDLE.
REQ-011 DATA SHALL send 5 to 8 bits per bits_per_char, latched at the IDLE to START transfer; mid-character changes SHALL be ignored.
REQ-012 After STOP, SHALL go to IDLE if THR is empty; otherwise SHALL reload from THR and go straight to START with no idle bit.
REQ-013 If TxEN drops mid-character, SHALL finish the current character and any character already in THR, then stay in IDLE.
REQ-014 If TxReset=0 in any cycle, SHALL next cycle be in IDLE with THR empty, the tick count at 0 and TxD=1; this SHALL take priority over a same-cycle write.
REQ-015 If a write and the THR-to-shifter transfer occur in the same cycle, the transfer SHALL happen first and the write SHALL be accepted into THR.
REQ-016 The tick counter SHALL reset to 0 at each state entry and SHALL wrap to 0 on reaching TICKS_PER_BIT-1.

Reset
REQ-017 reset=1 SHALL give: state IDLE, THR empty, shifter 0, counters 0, TxD=1, TxRDY=0, TxEMT=1.
REQ-018 reset SHALL take priority over TxReset, writes and baud_tick.

Configuration
REQ-019 Macro TX_PARITY_EN SHALL add input parity_mode[1:0] (00 even, 01 odd, 1x none) and the PARITY state after DATA.
REQ-020 Parity SHALL be computed over the sent bits only; with parity_mode=1x, PARITY SHALL be skipped.
REQ-021 Without TX_PARITY_EN, the port, the state and the logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-022 A shared package SHALL hold the state enum, bits_per_char encodings, parity_mode encodings and the TICKS_PER_BIT default.
REQ-023 A sub-module tx_baud_div (tick counter with bit_done strobe) SHALL be instantiated; all other logic SHALL be inline.

Verification
REQ-024 Scenario: reset, TxEN=1, write 0x55, 8 bits, TICKS_PER_BIT=16 -> TxD gives 0,1,0,1,0,1,0,1,0,1, each 16 ticks; TxEMT=1 after STOP.
REQ-025 Scenario: write 0xA3 then 0x0F while the first is in DATA -> second START directly follows first STOP; TxRDY=0 from second write until reload.
REQ-026 Scenario: TxEN=0, write 0x12 -> ignored, TxD stays 1, TxEMT stays 1, TxRDY=0.
REQ-027 Scenario: TxReset=0 pulse during bit 3 of 0xFF -> TxD=1 next cycle, state IDLE, TxEMT=1, same-cycle write dropped.
REQ-028 Scenario: thr_cs held 5 cycles, r_w=0 -> exactly one character sent.
REQ-029 Scenario (TX_PARITY_EN): 7 bits, odd parity, data 0x07 -> parity bit 0; even parity -> parity bit 1.
